// File: rtl/io_port_controller.sv
// Memory-mapped I/O port controller: synchronized/debounced 8-bit input port,
// latched 32-bit output port and sticky change/overrun status on the data bus.
module io_port_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] IN_ADDR         = 32'h1001_0024,
    parameter logic [31:0] OUT_ADDR        = 32'h1001_0028,
    parameter logic [31:0] STATUS_ADDR     = 32'h1001_002C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PinsIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [7:0]  PortInSync,
    output logic [31:0] PortOut,
    output logic        Changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       r_s1;
    logic [7:0]       r_s2;
    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_stable;
    logic [31:0]      r_port_out;
    logic             r_changed;
    logic             r_overrun;

    logic w_hit_in;
    logic w_hit_out;
    logic w_hit_status;
    logic w_accept;
    logic w_clr_changed;
    logic w_clr_overrun;

    assign w_hit_in     = (Address == IN_ADDR);
    assign w_hit_out    = (Address == OUT_ADDR);
    assign w_hit_status = (Address == STATUS_ADDR);
    assign Hit          = w_hit_in | w_hit_out | w_hit_status;

    // Mirrors the final branch of the debounce chain below.
    assign w_accept = (r_s2 == r_cand) && (r_cnt >= CNT_MAX) && (r_cand != r_stable);

    assign w_clr_changed = (MemRead && w_hit_in) ||
                           (MemWrite && w_hit_status && WriteData[0]);
    assign w_clr_overrun = MemWrite && w_hit_status && WriteData[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else begin
            r_s1 <= PinsIn;
            r_s2 <= r_s1;
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
            end else if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (r_cand != r_stable) begin
                r_stable <= r_cand;
            end
        end
    end

    // Set has priority over every clear source for both sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port_out <= '0;
            r_changed  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (MemWrite && w_hit_out) begin
                r_port_out <= WriteData;
            end
            if (w_accept) begin
                r_changed <= 1'b1;
            end else if (w_clr_changed) begin
                r_changed <= 1'b0;
            end
            if (w_accept && r_changed && !w_clr_changed) begin
                r_overrun <= 1'b1;
            end else if (w_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (w_hit_in) begin
            ReadData = {24'b0, r_stable};
        end else if (w_hit_out) begin
            ReadData = r_port_out;
        end else if (w_hit_status) begin
            ReadData = {30'b0, r_overrun, r_changed};
        end
    end

    assign PortInSync = r_stable;
    assign PortOut    = r_port_out;
    assign Changed    = r_changed;

endmodule
